key_debouncer: RTL

Parametrised multi-channel push-button conditioner. Synchronises N_CH raw active-low switch inputs, debounces them with a shared sample tick and a per-channel stability counter, and produces a clean level plus one-cycle press, release, long-press and auto-repeat strobes. It sits between the board switch pins and the stopwatch control FSM, and replaces single-channel edge-only debouncing.

---
 rtl/key_debouncer_pkg.sv | 16 +
 rtl/key_debounce_ch.sv | 126 ++++++++++++
 rtl/key_debouncer.sv | 58 +++++
 3 files changed

// File: rtl/key_debouncer_pkg.sv
// Shared types and helpers for the key_debouncer push-button conditioner.
// Holds the per-channel FSM state type and a counter width helper.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_t;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 3-flop synchroniser, stability counter, IDLE/PRESSED/HELD FSM.
// Strobes are registered and appear the cycle after the deciding tick; no backpressure.
module key_debounce_ch
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_N     = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic CLK,
  input  logic XRST,
  input  logic xdin,
  input  logic tick,
  output logic level,
  output logic press_stb,
  output logic release_stb,
  output logic long_stb,
  output logic repeat_stb
);

  localparam int SW = cnt_width(STABLE_N);
  localparam int HW = cnt_width(LONG_TICKS);
  localparam int RW = cnt_width(REPEAT_TICKS);
  localparam logic [SW-1:0] STABLE_C = SW'(STABLE_N);
  localparam logic [HW-1:0] LONG_C   = HW'(LONG_TICKS);
  localparam logic [RW-1:0] REPEAT_C = RW'(REPEAT_TICKS);

  logic [2:0]    sync_q;
  key_state_t    state, state_nxt;
  logic [SW-1:0] stab_cnt, stab_nxt, stab_inc;
  logic [HW-1:0] hold_cnt, hold_nxt, hold_inc;
  logic [RW-1:0] rep_cnt, rep_nxt, rep_inc;
  logic          level_nxt, press_nxt, release_nxt, long_nxt, repeat_nxt;
  logic          sample, accept;

  assign sample   = ~sync_q[2];
  assign stab_inc = stab_cnt + SW'(1);
  assign hold_inc = hold_cnt + HW'(1);
  assign rep_inc  = rep_cnt + RW'(1);
  assign accept   = tick && (sample != level) && (stab_inc == STABLE_C);

  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      sync_q      <= 3'b111;
      state       <= IDLE;
      stab_cnt    <= '0;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      level       <= 1'b0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
      long_stb    <= 1'b0;
      repeat_stb  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[1:0], xdin};
      state       <= state_nxt;
      stab_cnt    <= stab_nxt;
      hold_cnt    <= hold_nxt;
      rep_cnt     <= rep_nxt;
      level       <= level_nxt;
      press_stb   <= press_nxt;
      release_stb <= release_nxt;
      long_stb    <= long_nxt;
      repeat_stb  <= repeat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    stab_nxt    = stab_cnt;
    hold_nxt    = hold_cnt;
    rep_nxt     = rep_cnt;
    level_nxt   = level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    if (tick) begin
      if (sample == level || accept) begin
        stab_nxt = '0;
      end else begin
        stab_nxt = stab_inc;
      end
      if (accept) begin
        level_nxt = sample;
      end
      // An accepted release pre-empts a LONG or REPEAT threshold on the same tick.
      case (state)
        IDLE: begin
          if (accept && sample) begin
            state_nxt = PRESSED;
            hold_nxt  = '0;
            press_nxt = 1'b1;
          end
        end
        PRESSED: begin
          if (accept && !sample) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else if (hold_cnt < LONG_C) begin
            hold_nxt = hold_inc;
            if (hold_inc == LONG_C) begin
              state_nxt = HELD;
              long_nxt  = 1'b1;
              rep_nxt   = '0;
            end
          end
        end
        HELD: begin
          if (accept && !sample) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else if (rep_cnt < REPEAT_C) begin
            rep_nxt = rep_inc;
            if (rep_inc == REPEAT_C) begin
              repeat_nxt = 1'b1;
              rep_nxt    = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel push-button conditioner: shared sample-tick prescaler plus N_CH channels.
// Press/release strobes lag the pin by about STABLE_N ticks plus 4 clocks; no backpressure.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_N     = 8,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic            CLK,
  input  logic            XRST,
  input  logic [N_CH-1:0] XDIN,
  output logic [N_CH-1:0] LEVEL,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE,
  output logic [N_CH-1:0] LONG,
  output logic [N_CH-1:0] REPEAT
);

  localparam int PW = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + PW'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    key_debounce_ch #(
      .STABLE_N    (STABLE_N),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_ch (
      .CLK        (CLK),
      .XRST       (XRST),
      .xdin       (XDIN[g]),
      .tick       (tick),
      .level      (LEVEL[g]),
      .press_stb  (PRESS[g]),
      .release_stb(RELEASE[g]),
      .long_stb   (LONG[g]),
      .repeat_stb (REPEAT[g])
    );
  end

endmodule
